// File: rtl/bram_weight_pingpong.sv
// Ping-pong weight store: wide writes into one bank, narrow lane reads from the other.
// Optional sticky error flags are built when BRAM_WEIGHT_PINGPONG_ERR_EN is defined.
module bram_weight_pingpong #(
  parameter int DATA_WIDTH_IN  = 128,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int DEPTH          = 2048
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [$clog2(DEPTH)-1:0]                wr_addr,
  input  logic [DATA_WIDTH_IN-1:0]                data_in,
  input  logic                                    wr_bank_done,
  output logic                                    wr_bank_free,
  input  logic                                    rd_en,
  input  logic [$clog2(DEPTH*(DATA_WIDTH_IN/DATA_WIDTH_OUT))-1:0] rd_addr,
  input  logic                                    rd_bank_release,
  output logic                                    rd_bank_ready,
  output logic [DATA_WIDTH_OUT-1:0]               data_out,
  output logic                                    data_out_valid,
  output logic                                    wr_bank_sel,
  output logic                                    rd_bank_sel,
  output logic                                    err_wr_full,
  output logic                                    err_rd_empty
);

  localparam int LANES     = DATA_WIDTH_IN / DATA_WIDTH_OUT;
  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int LW        = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int RAW       = $clog2(DEPTH * LANES);

  (* ram_style = "block" *) logic [DATA_WIDTH_IN-1:0] mem0 [DEPTH];
  (* ram_style = "block" *) logic [DATA_WIDTH_IN-1:0] mem1 [DEPTH];

  logic [1:0] full_q, full_d;
  logic       wr_sel_q, wr_sel_d;
  logic       rd_sel_q, rd_sel_d;

  logic                      wr_acc, done_acc, rd_acc, rel_acc;
  logic [AW-1:0]             rd_word;
  logic [LW-1:0]             rd_lane;

  logic [DATA_WIDTH_IN-1:0]  rdata0_q, rdata1_q, word1;
  logic                      vld1_q, bsel1_q;
  logic [LW-1:0]             lane1_q;
  logic [DATA_WIDTH_OUT-1:0] lane_data;
  logic [DATA_WIDTH_OUT-1:0] dout_q;
  logic                      vld2_q;

  assign wr_bank_free  = !full_q[wr_sel_q];
  assign rd_bank_ready = full_q[rd_sel_q];
  assign wr_bank_sel   = wr_sel_q;
  assign rd_bank_sel   = rd_sel_q;
  assign data_out      = dout_q;
  assign data_out_valid = vld2_q;

  assign wr_acc   = wr_en && wr_bank_free;
  assign done_acc = wr_bank_done && wr_bank_free;
  assign rd_acc   = rd_en && rd_bank_ready;
  assign rel_acc  = rd_bank_release && rd_bank_ready;

  assign rd_word = rd_addr[RAW-1:LANE_BITS];

  generate
    if (LANE_BITS > 0) begin : g_lane
      assign rd_lane = rd_addr[LANE_BITS-1:0];
    end else begin : g_nolane
      assign rd_lane = '0;
    end
  endgenerate

  // Next-state of bank ownership; done and release can never hit the same bank.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (rel_acc) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
    if (done_acc) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
    end
  end

  // Bank ownership state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 2'b00;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end

  // Bank 0 port: write and read-first registered read.
  always_ff @(posedge clk) begin
    if (wr_acc && !wr_sel_q) mem0[wr_addr] <= data_in;
    if (rd_acc && !rd_sel_q) rdata0_q <= mem0[rd_word];
  end

  // Bank 1 port: write and read-first registered read.
  always_ff @(posedge clk) begin
    if (wr_acc && wr_sel_q) mem1[wr_addr] <= data_in;
    if (rd_acc && rd_sel_q) rdata1_q <= mem1[rd_word];
  end

  // Stage 1 control: the lane and bank travel with the fetched word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_q  <= 1'b0;
      lane1_q <= '0;
      bsel1_q <= 1'b0;
    end else begin
      vld1_q <= rd_acc;
      if (rd_acc) begin
        lane1_q <= rd_lane;
        bsel1_q <= rd_sel_q;
      end
    end
  end

  assign word1 = bsel1_q ? rdata1_q : rdata0_q;

  // Lane select from the stage-1 word.
  always_comb begin
    lane_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane1_q == LW'(k)) lane_data = word1[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
    end
  end

  // Stage 2: registered lane and valid; data holds when no read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      vld2_q <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) dout_q <= lane_data;
    end
  end

`ifdef BRAM_WEIGHT_PINGPONG_ERR_EN
  logic err_wr_q, err_rd_q;

  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_wr_q <= 1'b0;
      err_rd_q <= 1'b0;
    end else begin
      if ((wr_en || wr_bank_done) && !wr_bank_free) err_wr_q <= 1'b1;
      if (rd_en && !rd_bank_ready) err_rd_q <= 1'b1;
    end
  end

  assign err_wr_full  = err_wr_q;
  assign err_rd_empty = err_rd_q;
`else
  assign err_wr_full  = 1'b0;
  assign err_rd_empty = 1'b0;
`endif

endmodule

// File: tb/tb_bram_weight_pingpong.sv
// Scoreboard bench for bram_weight_pingpong.
// Two instances: 32-bit lanes (LANES=4) and 16-bit lanes (LANES=8).
module tb_bram_weight_pingpong;

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef BRAM_WEIGHT_PINGPONG_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic         wr_en0, wr_done0, rd_en0, rel0;
  logic [10:0]  wr_addr0;
  logic [127:0] din0;
  logic [12:0]  rd_addr0;
  logic [31:0]  dout0;
  logic         free0, ready0, vld0, wsel0, rsel0, ewr0, erd0;

  bram_weight_pingpong u_dut0 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .data_in(din0),
    .wr_bank_done(wr_done0), .wr_bank_free(free0),
    .rd_en(rd_en0), .rd_addr(rd_addr0),
    .rd_bank_release(rel0), .rd_bank_ready(ready0),
    .data_out(dout0), .data_out_valid(vld0),
    .wr_bank_sel(wsel0), .rd_bank_sel(rsel0),
    .err_wr_full(ewr0), .err_rd_empty(erd0)
  );

  logic         wr_en1, wr_done1, rd_en1, rel1;
  logic [10:0]  wr_addr1;
  logic [127:0] din1;
  logic [13:0]  rd_addr1;
  logic [15:0]  dout1;
  logic         free1, ready1, vld1, wsel1, rsel1, ewr1, erd1;

  bram_weight_pingpong #(.DATA_WIDTH_OUT(16)) u_dut1 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .data_in(din1),
    .wr_bank_done(wr_done1), .wr_bank_free(free1),
    .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_bank_release(rel1), .rd_bank_ready(ready1),
    .data_out(dout1), .data_out_valid(vld1),
    .wr_bank_sel(wsel1), .rd_bank_sel(rsel1),
    .err_wr_full(ewr1), .err_rd_empty(erd1)
  );

  function automatic logic [127:0] mk32(int i, int base);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = 32'(base + 4*i + k);
    return w;
  endfunction

  function automatic logic [127:0] mk16(int i);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(8*i + k);
    return w;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en0 = 0; wr_done0 = 0; rd_en0 = 0; rel0 = 0;
    wr_en1 = 0; wr_done1 = 0; rd_en1 = 0; rel1 = 0;
  endtask

  task automatic rd0(int a, logic [31:0] e);
    exp_t x;
    rd_en0 = 1;
    rd_addr0 = 13'(a);
    x.d = e;
    x.due = cyc + 2;
    q0.push_back(x);
  endtask

  task automatic rd1(int a, logic [31:0] e);
    exp_t x;
    rd_en1 = 1;
    rd_addr1 = 14'(a);
    x.d = e;
    x.due = cyc + 2;
    q1.push_back(x);
  endtask

  // Monitor for the 32-bit-lane instance.
  always @(negedge clk) begin
    if (vld0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL rd0_unexpected: got %h at cycle %0d, required no valid", dout0, cyc);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (dout0 !== e.d || cyc != e.due) begin
          errors++;
          $display("FAIL rd0_data: got %h @%0d required %h @%0d", dout0, cyc, e.d, e.due);
        end
      end
    end
  end

  // Monitor for the 16-bit-lane instance.
  always @(negedge clk) begin
    if (vld1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rd1_unexpected: got %h at cycle %0d, required no valid", dout1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if ({16'h0, dout1} !== e.d || cyc != e.due) begin
          errors++;
          $display("FAIL rd1_data: got %h @%0d required %h @%0d", dout1, cyc, e.d, e.due);
        end
      end
    end
  end

  initial begin
    wr_en0 = 0; wr_done0 = 0; rd_en0 = 0; rel0 = 0;
    wr_addr0 = '0; din0 = '0; rd_addr0 = '0;
    wr_en1 = 0; wr_done1 = 0; rd_en1 = 0; rel1 = 0;
    wr_addr1 = '0; din1 = '0; rd_addr1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    tick();

    chk("rst_valid", 32'(vld0), 0);
    chk("rst_dout", dout0, 0);
    chk("rst_free", 32'(free0), 1);
    chk("rst_ready", 32'(ready0), 0);
    chk("rst_wsel", 32'(wsel0), 0);
    chk("rst_rsel", 32'(rsel0), 0);
    chk("rst_errwr", 32'(ewr0), 0);
    chk("rst_errrd", 32'(erd0), 0);

    rd_en0 = 1; rd_addr0 = '0;
    tick(); tick(); tick();
    chk("empty_valid", 32'(vld0), 0);
    chk("empty_dout", dout0, 0);
    chk("empty_errrd", 32'(erd0), 32'(ERR_ON));

    for (int i = 0; i < 4; i++) begin
      wr_en0 = 1; wr_addr0 = 11'(i); din0 = mk32(i, 0);
      tick();
    end
    wr_done0 = 1;
    tick();
    chk("fill_wsel", 32'(wsel0), 1);
    chk("fill_ready", 32'(ready0), 1);
    chk("fill_free", 32'(free0), 1);
    chk("fill_rsel", 32'(rsel0), 0);

    for (int a = 0; a < 16; a++) begin
      rd0(a, 32'(a));
      tick();
    end
    repeat (3) tick();

    for (int i = 0; i < 4; i++) begin
      wr_en0 = 1; wr_addr0 = 11'(i); din0 = mk32(i, 'h100);
      rd0(i + 8, 32'(i + 8));
      tick();
    end
    wr_done0 = 1;
    tick();
    chk("both_wsel", 32'(wsel0), 0);
    chk("both_free", 32'(free0), 0);
    chk("both_ready", 32'(ready0), 1);

    wr_en0 = 1; wr_addr0 = '0; din0 = 128'hDEAD;
    tick();
    chk("drop_errwr", 32'(ewr0), 32'(ERR_ON));
    rd0(0, 0);
    tick();
    rd0(3, 3);
    tick();

    rd0(3, 3); rel0 = 1;
    tick();
    rd_addr0 = '0;
    tick(); tick();
    chk("rel_rsel", 32'(rsel0), 1);
    chk("rel_wsel", 32'(wsel0), 0);
    chk("rel_free", 32'(free0), 1);
    chk("rel_ready", 32'(ready0), 1);
    chk("rel_dout_hold", dout0, 3);

    rd0(5, 'h105);
    tick();
    repeat (3) tick();

    rd_en0 = 1; rd_addr0 = 13'd6;
    tick();
    rd_en0 = 1; rd_addr0 = 13'd7;
    #2 rst = 1;
    @(posedge clk);
    #1;
    rd_en0 = 0;
    chk("rstmid_valid", 32'(vld0), 0);
    chk("rstmid_dout", dout0, 0);
    chk("rstmid_free", 32'(free0), 1);
    chk("rstmid_ready", 32'(ready0), 0);
    chk("rstmid_wsel", 32'(wsel0), 0);
    chk("rstmid_rsel", 32'(rsel0), 0);
    rst = 0;
    repeat (4) tick();
    chk("post_rst_valid", 32'(vld0), 0);

    for (int i = 0; i < 4; i++) begin
      wr_en1 = 1; wr_addr1 = 11'(i); din1 = mk16(i);
      tick();
    end
    wr_done1 = 1;
    tick();
    chk("l8_wsel", 32'(wsel1), 1);
    chk("l8_ready", 32'(ready1), 1);
    for (int a = 0; a < 32; a++) begin
      rd1(a, 32'(a));
      tick();
    end
    repeat (5) tick();

    chk("q0_drain", 32'(q0.size()), 0);
    chk("q1_drain", 32'(q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
